// File: rtl/vid_stream_out_pkg.sv
// vid_stream_out_pkg: shared FSM encodings, geometry defaults
// and sizing helpers for the denoise output formatter.
package vid_stream_out_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBLANK,
    ST_LWAIT,
    ST_ACTIVE,
    ST_HBLANK
  } vid_state_e;

  localparam int PIX_W          = 8;
  localparam int DEF_IMG_COL    = 640;
  localparam int DEF_IMG_ROW    = 480;
  localparam int DEF_H_BLANK    = 16;
  localparam int DEF_VS_LEN     = 4;
  localparam int DEF_V_BLANK    = 8;
  localparam int DEF_FIFO_DEPTH = 2048;

  function automatic int CLOG2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // width of a counter that runs 0..n-1, never narrower than 1 bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : CLOG2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vid_stream_out_sync_fifo.sv
// vid_stream_out_sync_fifo: single-clock pixel FIFO with registered
// read data, flush-with-write and an occupancy count.
module vid_stream_out_sync_fifo
  import vid_stream_out_pkg::*;
#(
  parameter int DW    = PIX_W,
  parameter int DEPTH = 16,
  localparam int AW   = CLOG2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   level_o,
  output logic          full_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] wr_addr;
  logic          empty;
  logic          do_wr;
  logic          do_rd;

  assign full_o    = level_q == (AW+1)'(DEPTH);
  assign empty     = level_q == '0;
  assign level_o   = level_q;
  assign rd_data_o = rd_data_q;

  // pointer and level update; a flush restarts at slot 0 and may
  // keep the word written in the same cycle
  always_comb begin
    do_wr    = wr_en_i & (flush_i | ~full_o);
    do_rd    = rd_en_i & ~empty & ~flush_i;
    wr_addr  = flush_i ? '0 : wr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = do_wr ? AW'(1) : '0;
      level_d  = do_wr ? (AW+1)'(1) : '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // storage array, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_addr] <= wr_data_i;
  end

  // read register holds zero except on the cycle after a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= do_rd ? mem_q[rd_ptr_q] : '0;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/vid_stream_out.sv
// vid_stream_out: buffers the sparse denoised pixel stream and
// replays it as a gap-free raster with vsync/href/de framing.
module vid_stream_out
  import vid_stream_out_pkg::*;
#(
  parameter int IMG_COL    = DEF_IMG_COL,
  parameter int IMG_ROW    = DEF_IMG_ROW,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int VS_LEN     = DEF_VS_LEN,
  parameter int V_BLANK    = DEF_V_BLANK,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int LVL_W     = CLOG2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_vld,
  input  logic             pix_sof,
  input  logic [7:0]       pix_data,
  output logic             out_de,
  output logic             out_href,
  output logic             out_vsync,
  output logic [7:0]       data_out,
  output logic [LVL_W-1:0] fifo_level,
  output logic             ovf,
  output logic             sync_err
);

  localparam int COL_W = cnt_w(IMG_COL);
  localparam int ROW_W = cnt_w(IMG_ROW);
  localparam int BLK_W = cnt_w(max3(H_BLANK, VS_LEN, V_BLANK));
  localparam int VB_N  = (V_BLANK > 0) ? V_BLANK : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROW - 1);
  localparam logic [BLK_W-1:0] VS_LAST  = BLK_W'(VS_LEN - 1);
  localparam logic [BLK_W-1:0] VB_LAST  = BLK_W'(VB_N - 1);
  localparam logic [BLK_W-1:0] HB_LAST  = BLK_W'(H_BLANK - 1);
  localparam logic [LVL_W-1:0] LINE_LVL = LVL_W'(IMG_COL);

  vid_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] line_q, line_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             resync_q, resync_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             de_q, de_d;
  logic             vs_q, vs_d;
  logic             sof_in;
  logic             sof_mid;
  logic             wr_en;
  logic             rd_en;
  logic             line_rdy;
  logic             blk_run;
  logic             fifo_full;
  logic [7:0]       rd_data;
  logic [LVL_W-1:0] level;

  // input qualification: pixels count only once a frame has begun
  always_comb begin
    sof_in   = pix_vld & pix_sof;
    sof_mid  = sof_in & (state_q != ST_IDLE);
    wr_en    = pix_vld & (pix_sof | (state_q != ST_IDLE));
    line_rdy = level >= LINE_LVL;
  end

  assign rd_en = state_d == ST_ACTIVE;

  vid_stream_out_sync_fifo #(
    .DW    (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (sof_in),
    .wr_en_i   (wr_en),
    .wr_data_i (pix_data),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .level_o   (level),
    .full_o    (fifo_full)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state; a fully buffered line skips LWAIT after hblank
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sof_in) state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (!resync_q && blk_q == VS_LAST)
          state_d = (V_BLANK == 0) ? ST_LWAIT : ST_VBLANK;
      end
      ST_VBLANK: begin
        if (blk_q == VB_LAST) state_d = ST_LWAIT;
      end
      ST_LWAIT: begin
        if (line_rdy) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (col_q == COL_LAST) state_d = ST_HBLANK;
      end
      ST_HBLANK: begin
        if (blk_q == HB_LAST) begin
          if (line_q == ROW_LAST) state_d = ST_IDLE;
          else if (line_rdy)      state_d = ST_ACTIVE;
          else                    state_d = ST_LWAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (sof_mid) state_d = ST_VSYNC;
  end

  // counters and sticky flags; resync holds vsync off for one cycle
  always_comb begin
    blk_run  = (state_q == ST_VBLANK) | (state_q == ST_HBLANK) |
               ((state_q == ST_VSYNC) & ~resync_q);
    blk_d    = '0;
    if (state_d == state_q && !sof_mid && blk_run)
      blk_d = blk_q + 1'b1;
    col_d    = '0;
    if (state_q == ST_ACTIVE && state_d == ST_ACTIVE)
      col_d = col_q + 1'b1;
    line_d   = line_q;
    if (sof_mid || state_q == ST_IDLE)
      line_d = '0;
    else if (state_q == ST_HBLANK && state_d != ST_HBLANK &&
             state_d != ST_IDLE)
      line_d = line_q + 1'b1;
    resync_d = sof_mid | (resync_q & (state_q != ST_VSYNC));
    ovf_d    = ovf_q | (wr_en & ~sof_in & fifo_full);
    err_d    = err_q | sof_mid;
  end

  // output decode from the upcoming state
  always_comb begin
    de_d = state_d == ST_ACTIVE;
    vs_d = (state_d == ST_VSYNC) & ~sof_mid;
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      line_q   <= '0;
      blk_q    <= '0;
      resync_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      col_q    <= col_d;
      line_q   <= line_d;
      blk_q    <= blk_d;
      resync_q <= resync_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      de_q     <= de_d;
      vs_q     <= vs_d;
    end
  end

  assign out_de     = de_q;
  assign out_href   = de_q;
  assign out_vsync  = vs_q;
  assign data_out   = rd_data;
  assign fifo_level = level;
  assign ovf        = ovf_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_vid_stream_out.sv
// tb_vid_stream_out: directed frames on a small geometry plus a
// shallow-FIFO instance for the overflow case.
module tb_vid_stream_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         href_bad = 0;
  int         zero_bad = 0;
  int         base;

  logic       a_vld = 1'b0, a_sof = 1'b0;
  logic [7:0] a_dat = 8'd0;
  logic       a_de, a_href, a_vs, a_ovf, a_err;
  logic [7:0] a_data;
  logic [4:0] a_lvl;

  logic       b_vld = 1'b0, b_sof = 1'b0;
  logic [7:0] b_dat = 8'd0;
  logic       b_de, b_href, b_vs, b_ovf, b_err;
  logic [7:0] b_data;
  logic [4:0] b_lvl;

  int de_cyc[$], de_dat[$], vs_cyc[$];
  int b_cyc[$], b_dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vid_stream_out #(
    .IMG_COL(8), .IMG_ROW(2), .H_BLANK(2),
    .VS_LEN(2), .V_BLANK(1), .FIFO_DEPTH(16)
  ) dut_a (
    .clk(clk), .rst(rst),
    .pix_vld(a_vld), .pix_sof(a_sof), .pix_data(a_dat),
    .out_de(a_de), .out_href(a_href), .out_vsync(a_vs),
    .data_out(a_data), .fifo_level(a_lvl),
    .ovf(a_ovf), .sync_err(a_err)
  );

  vid_stream_out #(
    .IMG_COL(16), .IMG_ROW(1), .H_BLANK(1),
    .VS_LEN(2), .V_BLANK(24), .FIFO_DEPTH(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .pix_vld(b_vld), .pix_sof(b_sof), .pix_data(b_dat),
    .out_de(b_de), .out_href(b_href), .out_vsync(b_vs),
    .data_out(b_data), .fifo_level(b_lvl),
    .ovf(b_ovf), .sync_err(b_err)
  );

  always @(negedge clk) begin
    if (a_de) begin
      de_cyc.push_back(cyc);
      de_dat.push_back(int'(a_data));
    end
    if (a_vs) vs_cyc.push_back(cyc);
    if (a_de !== a_href) href_bad++;
    if (!a_de && a_data !== 8'd0) zero_bad++;
    if (b_de) begin
      b_cyc.push_back(cyc);
      b_dq.push_back(int'(b_data));
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    de_cyc.delete();
    de_dat.delete();
    vs_cyc.delete();
  endtask

  task automatic feed(input int d0, input int gap, input int n,
                      output int b0);
    b0 = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) b0 = cyc;
      a_vld = 1'b1;
      a_sof = (k == 0);
      a_dat = 8'(d0 + k);
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        a_vld = 1'b0;
        a_sof = 1'b0;
      end
    end
    @(negedge clk);
    a_vld = 1'b0;
    a_sof = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int b0,
                             input int d0, input int s0, input int s1);
    int ec;
    check({tag, "_de_n"}, de_cyc.size(), 16);
    for (int i = 0; i < de_cyc.size() && i < 16; i++) begin
      ec = b0 + ((i < 8) ? s0 + i : s1 + i - 8);
      check($sformatf("%s_dat%0d", tag, i), de_dat[i], (d0 + i) & 255);
      check($sformatf("%s_cyc%0d", tag, i), de_cyc[i], ec);
    end
    check({tag, "_vs_n"}, vs_cyc.size(), 2);
    if (vs_cyc.size() > 0) check({tag, "_vs0"}, vs_cyc[0], b0 + 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_de", a_de, 0);
    check("rst_href", a_href, 0);
    check("rst_vs", a_vs, 0);
    check("rst_data", a_data, 0);
    check("rst_lvl", a_lvl, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_err", a_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    clr();
    feed(0, 1, 16, base);
    repeat (20) @(negedge clk);
    check_frame("basic", base, 0, 9, 19);
    check("basic_lvl_end", a_lvl, 0);
    check("basic_de_end", a_de, 0);

    clr();
    feed(100, 3, 16, base);
    repeat (15) @(negedge clk);
    check_frame("sparse", base, 100, 23, 47);

    clr();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_vld = 1'b1;
      a_sof = 1'b0;
      a_dat = 8'(200 + k);
    end
    @(negedge clk);
    a_vld = 1'b0;
    @(negedge clk);
    check("garb_lvl", a_lvl, 0);
    check("garb_vs_n", vs_cyc.size(), 0);
    feed(50, 1, 16, base);
    repeat (20) @(negedge clk);
    check_frame("garb", base, 50, 9, 19);

    clr();
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      if (k == 0) base = cyc;
      if (k == 11) check("mid_err_pre", a_err, 0);
      if (k == 12) begin
        check("mid_err", a_err, 1);
        check("mid_de_drop", a_de, 0);
        check("mid_lvl", a_lvl, 1);
      end
      a_vld = 1'b1;
      a_sof = (k == 0) || (k == 11);
      a_dat = (k < 11) ? 8'(k) : 8'(8'h80 + k - 11);
    end
    @(negedge clk);
    a_vld = 1'b0;
    a_sof = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_de_n", de_cyc.size(), 19);
    for (int i = 0; i < de_cyc.size() && i < 19; i++) begin
      check($sformatf("mid_dat%0d", i), de_dat[i],
            (i < 3) ? i : 8'h80 + i - 3);
      check($sformatf("mid_cyc%0d", i), de_cyc[i],
            base + ((i < 3) ? 9 + i : (i < 11) ? 17 + i : 19 + i));
    end
    check("mid_vs_n", vs_cyc.size(), 4);
    if (vs_cyc.size() == 4) begin
      check("mid_vs0", vs_cyc[0], base + 1);
      check("mid_vs2", vs_cyc[2], base + 13);
      check("mid_vs3", vs_cyc[3], base + 14);
    end
    check("mid_err_sticky", a_err, 1);

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) base = cyc;
      if (k == 16) begin
        check("ovf_lvl16", b_lvl, 16);
        check("ovf_pre", b_ovf, 0);
      end
      if (k == 17) check("ovf_set", b_ovf, 1);
      b_vld = 1'b1;
      b_sof = (k == 0);
      b_dat = 8'(k);
    end
    @(negedge clk);
    b_vld = 1'b0;
    b_sof = 1'b0;
    check("ovf_lvl_full", b_lvl, 16);
    repeat (45) @(negedge clk);
    check("ovf_de_n", b_cyc.size(), 16);
    if (b_cyc.size() == 16) begin
      check("ovf_cyc0", b_cyc[0], base + 28);
      check("ovf_dat0", b_dq[0], 0);
      check("ovf_dat15", b_dq[15], 15);
      check("ovf_cyc15", b_cyc[15], base + 43);
    end
    check("ovf_sticky", b_ovf, 1);
    check("ovf_lvl_end", b_lvl, 0);

    clr();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) base = cyc;
      if (k == 11) begin
        check("ar_de_pre", a_de, 1);
        check("ar_dat_pre", a_data, 2);
      end
      a_vld = 1'b1;
      a_sof = (k == 0);
      a_dat = 8'(k);
    end
    #2;
    rst = 1'b1;
    a_vld = 1'b0;
    a_sof = 1'b0;
    #1;
    check("ar_de", a_de, 0);
    check("ar_href", a_href, 0);
    check("ar_dat", a_data, 0);
    check("ar_lvl", a_lvl, 0);
    check("ar_err", a_err, 0);
    check("ar_ovf_b", b_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr();
    feed(64, 1, 16, base);
    repeat (20) @(negedge clk);
    check_frame("post_rst", base, 64, 9, 19);

    check("href_eq_de", href_bad, 0);
    check("data_zero_idle", zero_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vid_stream_out.md
# vid_stream_out

Output-side stream formatter for the denoise pipeline, the counterpart of the block extractor's input interface. It buffers the sparse, burst-y denoised pixel stream (`pix_vld`/`pix_data`) in an on-chip FIFO. It re-emits the pixels as a regular raster stream (`out_de`/`out_href`/`out_vsync`/`data_out`) in the same signalling used at the pipeline input, so results can be looped back, compared, or sent to a display or capture sink. Each line is emitted only when it is fully buffered, so output lines never stall mid-line.

## Interface
Parameters:
- `IMG_COL`, 640, active pixels per line
- `IMG_ROW`, 480, active lines per frame
- `H_BLANK`, 16, idle cycles after each active line (≥1)
- `VS_LEN`, 4, cycles `out_vsync` is high at frame start (≥1)
- `V_BLANK`, 8, idle cycles between vsync fall and first line (≥0)
- `FIFO_DEPTH`, 2048, pixel FIFO depth, power of two, ≥ `IMG_COL`

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, asynchronous, active-high
- `pix_vld` in 1: input pixel valid, no backpressure
- `pix_sof` in 1: start-of-frame, qualified by `pix_vld`, marks first pixel of a frame
- `pix_data` in 8: denoised pixel
- `out_de` out 1: output data enable
- `out_href` out 1: line active, identical to `out_de`
- `out_vsync` out 1: frame sync pulse, active-high
- `data_out` out 8: output pixel, valid when `out_de`=1, else 0
- `fifo_level` out clog2(FIFO_DEPTH)+1: current FIFO occupancy
- `ovf` out 1: sticky, pixel dropped because FIFO was full
- `sync_err` out 1: sticky, `pix_sof` arrived mid-frame

## Operation
- Reset: FSM=IDLE; FIFO empty; all outputs 0; counters 0.
- Write: `pix_vld`=1 and FIFO not full → push `pix_data`.
- Overflow: `pix_vld`=1 and FIFO full → drop the pixel and set `ovf`. `ovf` clears only on reset.
- FSM states:
  - IDLE: wait for an accepted pixel with `pix_sof`=1 → VSYNC. Pixels without sof in IDLE are discarded (not pushed).
  - VSYNC: `out_vsync`=1 for `VS_LEN` cycles → VBLANK.
  - VBLANK: `V_BLANK` cycles (0 means skip) → LWAIT.
  - LWAIT: wait until `fifo_level` ≥ `IMG_COL` → ACTIVE.
  - ACTIVE: `IMG_COL` cycles, one FIFO pop per cycle, `out_de`=`out_href`=1 → HBLANK.
  - HBLANK: `H_BLANK` cycles. If `line_cnt` = `IMG_ROW`-1 → IDLE, else increment `line_cnt` and → LWAIT.
- Underrun cannot occur, since ACTIVE is entered only with a full line buffered.
- Mid-frame sof: `pix_vld`&`pix_sof` with FSM ≠ IDLE:
  - set `sync_err`;
  - flush the FIFO, keeping only the sof pixel (written at level 0, so `fifo_level`=1 next cycle);
  - reset `line_cnt`;
  - drive `out_de`/`out_href`/`out_vsync` low and go to VSYNC next cycle.
- Sof in HBLANK of the last line is treated as mid-frame.
- Sof in IDLE is normal.
- Counters: column counter clog2(IMG_COL) bits; line counter clog2(IMG_ROW) bits; blank counter sized to max(`H_BLANK`, `VS_LEN`, `V_BLANK`). Wrap only by explicit reload, never by overflow.

## Timing
- All outputs registered. `out_de`, `out_href` and `data_out` change on the same edge, so pixel *n* of a line appears on the *n*-th `out_de` cycle.
- Latency from the accepted sof pixel to `out_vsync` rise: 1 cycle.
- Latency from the write that makes `fifo_level` = `IMG_COL` to the first `out_de`: 2 cycles (level update, then LWAIT→ACTIVE).
- Line period in steady state: `IMG_COL` + `H_BLANK` cycles; `out_de` is contiguous within a line.
- Simultaneous push and pop: level unchanged.
- `fifo_level` reflects the push/pop of the previous edge.
- Reset mid-line: outputs go to 0 asynchronously; FIFO contents discarded.

## Structure
- Shared include `vid_pkg.vh`:
  - FSM state encodings (IDLE, VSYNC, VBLANK, LWAIT, ACTIVE, HBLANK);
  - `CLOG2` function;
  - default geometry constants shared with the block extractor.
- Sub-module `sync_fifo` (8-bit, `FIFO_DEPTH`, registered read data, synchronous `flush` with concurrent write, `level` output), inferable to block RAM.
- FSM, counters and status flags live in `vid_stream_out`.

## Test plan
- Basic frame, `IMG_COL`=8, `IMG_ROW`=2, `H_BLANK`=2, `VS_LEN`=2, `V_BLANK`=1: feed 16 pixels 0..15 back-to-back with sof on pixel 0. Expect:
  - vsync high 2 cycles;
  - line 0 `data_out` 0..7 on 8 contiguous `out_de` cycles;
  - 2 idle cycles;
  - line 1 with 8..15;
  - return to IDLE.
- Sparse input (`pix_vld` every 3rd cycle): no `out_de` until 8 pixels are buffered, then 8 contiguous output cycles; no gaps within a line.
- Overflow, `FIFO_DEPTH`=16 with output held (`IMG_COL`=16 and input not yet complete): push 20 pixels without a line completing. Expect `ovf`=1, `fifo_level`=16, extra pixels dropped, `ovf` still 1 after the frame ends.
- Mid-frame sof during line 0 ACTIVE: `sync_err`=1, output drops low next cycle, VSYNC restarts, and the new frame emits the sof pixel as pixel 0.
- Pre-sof garbage: 5 pixels without sof in IDLE, then a proper frame. The garbage never appears; `fifo_level` stays 0 until sof.
- Async reset asserted mid-ACTIVE: all outputs 0 immediately, `ovf`/`sync_err` cleared, next frame normal.
